debounce_array: RTL

- N-channel switch/button debouncer; parametrised successor of the single-channel debouncer.
- Per channel: 2-flop input synchroniser, stability filter timed by a shared prescaler tick, debounced level, one-cycle rise/fall pulses, and an optional long-press pulse.
- Sits between board pins (switches/buttons) and control FSMs. Channels are fully independent and share only the tick.

---
 rtl/debounce_array_pkg.sv | 22 ++
 rtl/debounce_chan.sv | 106 ++++++++++
 rtl/debounce_array.sv | 58 +++++
 3 files changed

// File: rtl/debounce_array_pkg.sv
// rtl/debounce_array_pkg.sv - shared state encodings and default timing for the debouncer
package debounce_defs;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int DEF_N            = 4;
  localparam int DEF_TICK_DIV     = 50_000;
  localparam int DEF_STABLE_TICKS = 40;
  localparam int DEF_LONG_TICKS   = 2_000;
  localparam int DEF_CW           = 16;

  // Counter width for a 0..v-1 counter, never below one bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounced channel: synchroniser, stability FSM, edge and long-press pulses
module debounce_chan
  import debounce_defs::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int CW           = DEF_CW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] LONG_MAX    = CW'(LONG_TICKS);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam bit            LONG_EN     = (LONG_TICKS != 0);

  logic [1:0]    sync_q;
  logic          sync;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold_cnt;

  assign sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOW;
      cnt      <= '0;
      hold_cnt <= '0;
      level_o  <= 1'b0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      long_o   <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      long_o <= 1'b0;
      case (state)
        ST_LOW: begin
          if (sync) begin
            state <= ST_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state    <= ST_HIGH;
              level_o  <= 1'b1;
              rise_o   <= 1'b1;
              hold_cnt <= '0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_HIGH: begin
          if (!sync) begin
            state <= ST_WAIT_LOW;
            cnt   <= '0;
          end else if (tick && LONG_EN && (hold_cnt != LONG_MAX)) begin
            // Saturates at LONG_TICKS so a press yields exactly one long pulse.
            hold_cnt <= hold_cnt + CW'(1);
            if (hold_cnt == LONG_LAST) long_o <= 1'b1;
          end
        end
        ST_WAIT_LOW: begin
          if (sync) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state   <= ST_LOW;
              level_o <= 1'b0;
              fall_o  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= ST_LOW;
      endcase
    end
  end

endmodule

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - N-channel debouncer sharing one prescaler tick
module debounce_array
  import debounce_defs::*;
#(
  parameter int N            = DEF_N,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int CW           = DEF_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] long_o,
  output logic         tick_o
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;
  logic          tick;

  // Tick is decoded from the count so it is high exactly while the count sits at its last value.
  assign tick   = (div_cnt == DIV_LAST);
  assign tick_o = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .CW          (CW)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .sw     (sw_in[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .long_o (long_o[i])
    );
  end

endmodule
